// File: rtl/cfg_loader_if.sv
// cfg_loader_if: host, status and config-chain signals of the bitstream loader.
interface cfg_loader_if #(parameter int CNT_W = 11);
    logic             start;
    logic             abort;
    logic [31:0]      word_in;
    logic             word_valid;
    logic             word_ready;
    logic             cfg_in_start;
    logic             cfg_bit_in;
    logic             cfg_out_start;
    logic             busy;
    logic             done;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] bits_sent;
    modport slave (
        input  start, abort, word_in, word_valid, cfg_out_start,
        output word_ready, cfg_in_start, cfg_bit_in, busy, done, err_code, bits_sent
    );
    modport master (
        output start, abort, word_in, word_valid, cfg_out_start,
        input  word_ready, cfg_in_start, cfg_bit_in, busy, done, err_code, bits_sent
    );
endinterface

// File: rtl/cfg_loader.sv
// cfg_loader: serializes host words LSB-first into one config frame and waits for its return.
module cfg_loader #(
    parameter int FRAME_BITS = 1024,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = $clog2(FRAME_BITS + 1)
) (
    input logic         clk,
    input logic         crst,
    cfg_loader_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, WAIT_RET = 2'd3;
    logic [1:0]       state_q, state_d;
    logic [31:0]      sr_q, sr_d;
    logic [4:0]       idx_q, idx_d;
    logic [CNT_W-1:0] bits_q, bits_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic             last;
    // Frame end wins over the word boundary, so a full frame never asks for another word.
    assign last = (state_q == SHIFT) && (bits_q == CNT_W'(FRAME_BITS - 1));
    assign bus.word_ready   = (state_q == LOAD) || ((state_q == SHIFT) && (idx_q == 5'd31) && !last);
    assign bus.cfg_in_start = (state_q == SHIFT) && (bits_q == '0);
    assign bus.cfg_bit_in   = (state_q == SHIFT) && sr_q[0];
    assign bus.busy         = state_q != IDLE;
    assign bus.done         = done_q;
    assign bus.err_code     = err_q;
    assign bus.bits_sent    = bits_q;
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        bits_d  = bits_q;
        tcnt_d  = tcnt_q;
        done_d  = done_q;
        err_d   = err_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_d = LOAD;
                    done_d  = 1'b0;
                    err_d   = 2'd0;
                    bits_d  = '0;
                end
                LOAD: if (bus.word_valid) begin
                    sr_d    = bus.word_in;
                    idx_d   = 5'd0;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    sr_d   = sr_q >> 1;
                    idx_d  = idx_q + 5'd1;
                    bits_d = bits_q + CNT_W'(1);
                    if (last) begin
                        state_d = WAIT_RET;
                        tcnt_d  = '0;
                    end else if (idx_q == 5'd31) begin
                        if (bus.word_valid) begin
                            sr_d  = bus.word_in;
                            idx_d = 5'd0;
                        end else begin
                            err_d   = 2'd1;
                            state_d = IDLE;
                        end
                    end
                end
                default: if (bus.cfg_out_start) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 2'd2;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            endcase
        end
    end
    always_ff @(posedge clk or posedge crst) begin
        if (crst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            bits_q  <= '0;
            tcnt_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            bits_q  <= bits_d;
            tcnt_q  <= tcnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: directed vectors for a 40-bit frame loader plus a 32-bit frame instance.
module tb_cfg_loader;
    logic clk = 1'b0;
    logic crst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    always #5 clk = ~clk;
    cfg_loader_if #(.CNT_W(6)) a_if ();
    cfg_loader_if #(.CNT_W(6)) b_if ();
    cfg_loader #(.FRAME_BITS(40), .TIMEOUT(16)) dut_a (.clk(clk), .crst(crst), .bus(a_if.slave));
    cfg_loader #(.FRAME_BITS(32), .TIMEOUT(16)) dut_b (.clk(clk), .crst(crst), .bus(b_if.slave));
    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        bit          give2;
        int          ret;
        logic        exp_done;
        logic [1:0]  exp_err;
        int          exp_bits;
        int          exp_wait;
    } vec_t;
    vec_t vecs[4];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vec_t        t;
        logic [39:0] cap;
        logic [31:0] capb;
        int          starts;
        int          waits;
        vecs[0] = '{32'hA5A5_0F0F, 32'h0000_00C3, 1'b1, 4, 1'b1, 2'd0, 40, 5};
        vecs[1] = '{32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 2'd1, 32, 0};
        vecs[2] = '{32'hDEAD_BEEF, 32'h0000_005A, 1'b1, -1, 1'b0, 2'd2, 40, 16};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 1'b1, 0, 1'b1, 2'd0, 40, 1};
        a_if.start = 0; a_if.abort = 0; a_if.word_in = 0; a_if.word_valid = 0; a_if.cfg_out_start = 0;
        b_if.start = 0; b_if.abort = 0; b_if.word_in = 0; b_if.word_valid = 0; b_if.cfg_out_start = 0;
        repeat (2) tick;
        check("rst_ready", 32'(a_if.word_ready), 0);
        check("rst_busy", 32'(a_if.busy), 0);
        check("rst_done", 32'(a_if.done), 0);
        check("rst_err", 32'(a_if.err_code), 0);
        check("rst_bits", 32'(a_if.bits_sent), 0);
        check("rst_in_start", 32'(a_if.cfg_in_start), 0);
        crst = 0;
        tick;
        for (int v = 0; v < 4; v++) begin
            t = vecs[v];
            a_if.start = 1;
            tick;
            a_if.start = 0;
            check("load_ready", 32'(a_if.word_ready), 1);
            check("load_clr", {a_if.done, a_if.err_code}, 0);
            a_if.word_valid = 1;
            a_if.word_in = t.w0;
            tick;
            cap = '0;
            starts = 0;
            for (int k = 0; k < 40; k++) begin
                cap[k] = a_if.cfg_bit_in;
                starts += int'(a_if.cfg_in_start);
                if (k == 31) check("boundary_ready", 32'(a_if.word_ready), 1);
                if (k == 10) check("mid_ready", 32'(a_if.word_ready), 0);
                a_if.word_valid = (k == 31) && t.give2;
                a_if.word_in = t.w1;
                tick;
                if (k == 31 && !t.give2) break;
            end
            a_if.word_valid = 0;
            waits = 0;
            while (a_if.busy && waits < 64) begin
                a_if.cfg_out_start = (waits == t.ret);
                tick;
                a_if.cfg_out_start = 0;
                waits++;
            end
            check("in_start_cnt", starts, 1);
            check("frame_w0", cap[31:0], t.w0);
            if (t.give2) check("frame_w1", 32'(cap[39:32]), 32'(t.w1[7:0]));
            check("wait_cycles", waits, t.exp_wait);
            check("done", 32'(a_if.done), 32'(t.exp_done));
            check("err", 32'(a_if.err_code), 32'(t.exp_err));
            check("bits_sent", 32'(a_if.bits_sent), t.exp_bits);
            check("idle_bit", 32'(a_if.cfg_bit_in), 0);
            check("idle_busy", 32'(a_if.busy), 0);
        end
        // abort beats start in IDLE and leaves the sticky done alone
        a_if.abort = 1;
        a_if.start = 1;
        tick;
        a_if.abort = 0;
        a_if.start = 0;
        check("abort_start_busy", 32'(a_if.busy), 0);
        check("abort_start_done", 32'(a_if.done), 1);
        a_if.start = 1;
        tick;
        a_if.start = 0;
        a_if.word_valid = 1;
        a_if.word_in = 32'h0000_0001;
        tick;
        a_if.word_valid = 0;
        repeat (31) tick;
        a_if.word_valid = 1;
        a_if.word_in = 32'hFFFF_FFFF;
        a_if.abort = 1;
        tick;
        a_if.abort = 0;
        a_if.word_valid = 0;
        check("abort_busy", 32'(a_if.busy), 0);
        check("abort_bit", 32'(a_if.cfg_bit_in), 0);
        check("abort_err", 32'(a_if.err_code), 0);
        tick;
        check("abort_still_idle", 32'(a_if.busy), 0);
        a_if.start = 1;
        tick;
        a_if.start = 0;
        a_if.word_valid = 1;
        a_if.word_in = 32'h0000_0001;
        tick;
        a_if.word_valid = 0;
        check("restart_in_start", 32'(a_if.cfg_in_start), 1);
        check("restart_bit0", 32'(a_if.cfg_bit_in), 1);
        check("restart_bits", 32'(a_if.bits_sent), 0);
        // start while busy is ignored, then async reset mid-frame
        for (int k = 1; k < 10; k++) begin
            a_if.start = (k == 3);
            tick;
            if (k == 5) begin
                check("busy_start_bits", 32'(a_if.bits_sent), 5);
                check("busy_start_busy", 32'(a_if.busy), 1);
                check("busy_start_instart", 32'(a_if.cfg_in_start), 0);
            end
        end
        a_if.start = 0;
        check("pre_crst_bits", 32'(a_if.bits_sent), 9);
        #2 crst = 1;
        #1;
        check("crst_busy", 32'(a_if.busy), 0);
        check("crst_bits", 32'(a_if.bits_sent), 0);
        check("crst_bit", 32'(a_if.cfg_bit_in), 0);
        check("crst_ready", 32'(a_if.word_ready), 0);
        check("crst_flags", {a_if.done, a_if.err_code}, 0);
        tick;
        crst = 0;
        tick;
        check("post_crst_busy", 32'(a_if.busy), 0);
        // 32-bit frame: the boundary never requests a second word
        b_if.start = 1;
        tick;
        b_if.start = 0;
        check("b_load_ready", 32'(b_if.word_ready), 1);
        b_if.word_valid = 1;
        b_if.word_in = 32'h1357_9BDF;
        tick;
        b_if.word_in = 32'h2468_ACE0;
        capb = '0;
        for (int k = 0; k < 32; k++) begin
            capb[k] = b_if.cfg_bit_in;
            if (k == 31) check("b_boundary_ready", 32'(b_if.word_ready), 0);
            tick;
        end
        b_if.word_valid = 0;
        check("b_frame", capb, 32'h1357_9BDF);
        check("b_wait_busy", 32'(b_if.busy), 1);
        check("b_bits", 32'(b_if.bits_sent), 32);
        check("b_wait_bit", 32'(b_if.cfg_bit_in), 0);
        b_if.cfg_out_start = 1;
        tick;
        b_if.cfg_out_start = 0;
        check("b_done", 32'(b_if.done), 1);
        check("b_err", 32'(b_if.err_code), 0);
        check("b_idle", 32'(b_if.busy), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
